// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-stage valid/ready shift pipeline (srl/sll/sra, op 11 rotate-right when SHIFT_STAGE_ROR_EN is defined, else pass-through)
module shift_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic [15:0] out_count
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // S1: operand register
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q,  s1_data_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic [1:0]  s1_op_q,    s1_op_d;

  // S2: result register
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_data_q,  s2_data_d;
  logic        s2_zero_q,  s2_zero_d;

  logic [15:0] count_q, count_d;

  logic        out_xfer;
  logic        s2_accept;
  logic        move;
  logic        in_xfer;
  logic [31:0] shift_res;

  // Handshake qualifiers; in_ready already folds in flush, so in_xfer never fires during a flush
  always_comb begin
    out_xfer  = s2_valid_q & out_ready;
    s2_accept = ~s2_valid_q | out_xfer;
    move      = s1_valid_q & s2_accept;
    in_ready  = ~flush & (~s1_valid_q | s2_accept);
    in_xfer   = in_valid & in_ready;
  end

  // Shift result computed from the S1 contents
  always_comb begin
    shift_res = s1_data_q;
    case (s1_op_q)
      OP_SRL:  shift_res = s1_data_q >> s1_shamt_q;
      OP_SLL:  shift_res = s1_data_q << s1_shamt_q;
      OP_SRA:  shift_res = $unsigned($signed(s1_data_q) >>> s1_shamt_q);
      default: begin
`ifdef SHIFT_STAGE_ROR_EN
        // shamt 0 is special-cased so the left half does not shift by a full 32
        if (s1_shamt_q == 5'd0) begin
          shift_res = s1_data_q;
        end else begin
          shift_res = (s1_data_q >> s1_shamt_q) |
                      (s1_data_q << (6'd32 - {1'b0, s1_shamt_q}));
        end
`else
        shift_res = s1_data_q;
`endif
      end
    endcase
  end

  // Next-state for both stages and the transfer counter; flush wins over any handshake
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_shamt_d = s1_shamt_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;
    count_d    = count_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (out_xfer && count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
      // When S2 can take a result, it holds whatever S1 offers (possibly nothing)
      if (s2_accept) begin
        s2_valid_d = s1_valid_q;
      end
      if (move) begin
        s2_data_d = shift_res;
        s2_zero_d = (shift_res == 32'd0);
      end
      if (in_xfer) begin
        s1_valid_d = 1'b1;
        s1_data_d  = in_data;
        s1_shamt_d = in_shamt;
        s1_op_d    = in_op;
      end else if (move) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'd0;
      s1_shamt_q <= 5'd0;
      s1_op_q    <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 32'd0;
      s2_zero_q  <= 1'b1;
      count_q    <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_shamt_q <= s1_shamt_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_zero  = s2_zero_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - self-checking bench for shift_stage (honours SHIFT_STAGE_ROR_EN)
module tb_shift_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic [15:0] out_count;

  shift_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  int          cnt_m;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [63:0] dd;
    int n;
    n = int'(s);
    dd = {d, d};
    case (op)
      2'b00: return d >> n;
      2'b01: return d << n;
      2'b10: return d[31] ? ~((~d) >> n) : (d >> n);
      default: begin
`ifdef SHIFT_STAGE_ROR_EN
        dd = dd >> n;
        return dd[31:0];
`else
        return d;
`endif
      end
    endcase
  endfunction

  // Scoreboard update from the handshakes visible just before the edge, then advance one cycle
  task automatic tick();
    bit ix, ox;
    logic [31:0] e;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready && !flush;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (ox) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data_order", out_data, e);
          chk("out_zero_flag", {31'd0, out_zero}, {31'd0, (e == 32'd0)});
        end
        cnt_m++;
      end
      if (ix) exp_q.push_back(ref_shift(in_op, in_data, in_shamt));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_shamt = 5'd0; in_op = 2'b00;
    @(posedge clk); #3;
    reset = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    in_op = op; in_data = d; in_shamt = sh;
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;
    int idx;
    bit acc, stall;
    logic [31:0] prev_data;
    int lim;

    tbl[0]  = '{2'b00, 32'h80000000, 5'd31, 32'h00000001};
    tbl[1]  = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000};
    tbl[2]  = '{2'b01, 32'h00000001, 5'd31, 32'h80000000};
    tbl[3]  = '{2'b00, 32'h0000000F, 5'd4,  32'h00000000};
`ifdef SHIFT_STAGE_ROR_EN
    tbl[4]  = '{2'b11, 32'h00000001, 5'd1,  32'h80000000};
    tbl[9]  = '{2'b11, 32'h12345678, 5'd8,  32'h78123456};
`else
    tbl[4]  = '{2'b11, 32'h00000001, 5'd1,  32'h00000001};
    tbl[9]  = '{2'b11, 32'h12345678, 5'd8,  32'h12345678};
`endif
    tbl[5]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    tbl[6]  = '{2'b10, 32'h80000000, 5'd0,  32'h80000000};
    tbl[7]  = '{2'b11, 32'h12345678, 5'd0,  32'h12345678};
    tbl[8]  = '{2'b01, 32'hFFFFFFFF, 5'd16, 32'hFFFF0000};
    tbl[10] = '{2'b00, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF};

    // Reset state while reset is held
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_shamt = 5'd0; in_op = 2'b00;
    cnt_m = 0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_zero",  {31'd0, out_zero}, 32'd1);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table vectors: single op, two-cycle latency
    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      out_ready = 1'b1; in_valid = 1'b1;
      set_op(v.op, v.d, v.sh);
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid_early", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, v.exp);
      chk($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, (v.exp == 32'd0)});
      tick();
    end

    // Back-pressure: 4 ops, out_ready low for 5 cycles
    do_reset();
    idx = 0; out_ready = 1'b0; held = ref_shift(2'b00, 32'hA0000000, 5'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      set_op(2'(idx), 32'hA0000000 + 32'(idx), 5'(idx + 1));
      #1;
      if (c == 2) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (c >= 1) begin
        chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        chk("bp_data_held", out_data, held);
      end
    end
    chk("bp_accepted_two", 32'(idx), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      in_valid = (idx < 4);
      set_op(2'(idx), 32'hA0000000 + 32'(idx), 5'(idx + 1));
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 32'(idx), 32'd4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_count", {16'd0, out_count}, 32'd4);

    // Flush with both stages full
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(2'b01, 32'h3, 5'd2); #1; tick();
    set_op(2'b00, 32'h30, 5'd1); #1; tick();
    chk("fl_full_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1; #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_count", {16'd0, out_count}, 32'd0);
    tick(); tick();
    chk("fl_stays_empty", {31'd0, out_valid}, 32'd0);

    // Randomised traffic against the scoreboard
    do_reset();
    stall = 1'b0; prev_data = 32'd0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 24) == 0);
      set_op(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      #1;
      chk("rnd_in_ready", {31'd0, in_ready},
          {31'd0, (!flush && (exp_q.size() < 2 || out_ready))});
      if (stall) begin
        chk("rnd_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("rnd_hold_data", out_data, prev_data);
      end
      if (out_valid) chk("rnd_zero", {31'd0, out_zero}, {31'd0, (out_data == 32'd0)});
      stall = out_valid && !out_ready && !flush;
      prev_data = out_data;
      tick();
      chk("rnd_count", {16'd0, out_count}, 32'(cnt_m));
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    // Counter saturation
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    lim = 0;
    while (cnt_m < 65535 && lim < 70000) begin
      set_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom));
      #1;
      tick();
      lim++;
    end
    chk("sat_preload", {16'd0, out_count}, 32'd65535);
    lim = 0;
    while (cnt_m < 65536 && lim < 5) begin
      #1;
      tick();
      lim++;
    end
    chk("sat_reached", 32'(cnt_m), 32'd65536);
    chk("sat_hold", {16'd0, out_count}, 32'h0000FFFF);

    // Async reset pulse mid-stream, checked before any further edge
    out_ready = 1'b0;
    #3;
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_out_data",  out_data, 32'd0);
    chk("ar_out_zero",  {31'd0, out_zero}, 32'd1);
    chk("ar_out_count", {16'd0, out_count}, 32'd0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ar_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
